// File: rtl/slow_debug_multi.sv
// Per-channel pulse stretcher / edge toggler for debug visibility; O_slow follows a sampled edge by 1 cycle (+2 with SLOW_DEBUG_SYNC_EN).
// No backpressure: strobes are consumed every cycle, edges arriving during a stretch are merged and counted.
module slow_debug_multi #(
  parameter int pCHANNELS    = 8,
  parameter int pCOUNT_WIDTH = 8,
  parameter int pMERGE_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [pCHANNELS-1:0]              I_fast,
  input  logic [pCOUNT_WIDTH-1:0]           I_hold,
  input  logic [pCHANNELS-1:0]              I_toggle_mode,
  input  logic                              I_retrigger,
  input  logic                              I_clear_merged,
  output logic [pCHANNELS-1:0]              O_slow,
  output logic [pCHANNELS*pMERGE_WIDTH-1:0] O_merged,
  output logic                              O_active
);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_LOW} state_t;

  logic [pCHANNELS-1:0] fast_s;

`ifdef SLOW_DEBUG_SYNC_EN
  logic [pCHANNELS-1:0] sync_1;
  logic [pCHANNELS-1:0] sync_2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= I_fast;
      sync_2 <= sync_1;
    end
  end

  assign fast_s = sync_2;
`else
  assign fast_s = I_fast;
`endif

  logic [pCHANNELS-1:0]    fast_r;
  logic [pCHANNELS-1:0]    mode_q;
  logic [pCHANNELS-1:0]    slow_q, slow_d;
  logic                    active_q, active_d;
  state_t                  state_q  [pCHANNELS];
  state_t                  state_d  [pCHANNELS];
  logic [pCOUNT_WIDTH-1:0] count_q  [pCHANNELS];
  logic [pCOUNT_WIDTH-1:0] count_d  [pCHANNELS];
  logic [pMERGE_WIDTH-1:0] merged_q [pCHANNELS];
  logic [pMERGE_WIDTH-1:0] merged_d [pCHANNELS];

  logic [pCHANNELS-1:0]    edge_det;
  logic [pCOUNT_WIDTH-1:0] hold_eff;

  assign edge_det = fast_s & ~fast_r;
  assign hold_eff = (I_hold == '0) ? pCOUNT_WIDTH'(1) : I_hold;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    slow_d   = slow_q;
    merged_d = merged_q;
    active_d = 1'b0;
    for (int n = 0; n < pCHANNELS; n++) begin
      active_d = active_d | (state_q[n] != IDLE);
      // A mode flip restarts the channel cleanly; any edge this cycle is dropped.
      if (mode_q[n] != I_toggle_mode[n]) begin
        state_d[n] = IDLE;
        slow_d[n]  = 1'b0;
        count_d[n] = '0;
      end else if (I_toggle_mode[n]) begin
        state_d[n] = IDLE;
        if (edge_det[n]) slow_d[n] = ~slow_q[n];
      end else begin
        case (state_q[n])
          IDLE: begin
            if (edge_det[n]) begin
              state_d[n] = HOLD;
              count_d[n] = hold_eff;
              slow_d[n]  = 1'b1;
            end
          end
          HOLD: begin
            if (edge_det[n] && (merged_q[n] != {pMERGE_WIDTH{1'b1}}))
              merged_d[n] = merged_q[n] + pMERGE_WIDTH'(1);
            if (edge_det[n] && I_retrigger) begin
              count_d[n] = hold_eff;
            end else if (count_q[n] == pCOUNT_WIDTH'(1)) begin
              if (fast_s[n]) begin
                state_d[n] = WAIT_LOW;
              end else begin
                state_d[n] = IDLE;
                slow_d[n]  = 1'b0;
              end
            end else begin
              count_d[n] = count_q[n] - pCOUNT_WIDTH'(1);
            end
          end
          WAIT_LOW: begin
            if (!fast_s[n]) begin
              state_d[n] = IDLE;
              slow_d[n]  = 1'b0;
            end
          end
          default: begin
            state_d[n] = IDLE;
            slow_d[n]  = 1'b0;
          end
        endcase
      end
      if (I_clear_merged) merged_d[n] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fast_r   <= '0;
      mode_q   <= '0;
      slow_q   <= '0;
      active_q <= 1'b0;
      for (int n = 0; n < pCHANNELS; n++) begin
        state_q[n]  <= IDLE;
        count_q[n]  <= '0;
        merged_q[n] <= '0;
      end
    end else begin
      fast_r   <= fast_s;
      mode_q   <= I_toggle_mode;
      slow_q   <= slow_d;
      active_q <= active_d;
      state_q  <= state_d;
      count_q  <= count_d;
      merged_q <= merged_d;
    end
  end

  always_comb begin
    O_merged = '0;
    for (int n = 0; n < pCHANNELS; n++)
      O_merged[n*pMERGE_WIDTH +: pMERGE_WIDTH] = merged_q[n];
  end

  assign O_slow   = slow_q;
  assign O_active = active_q;

endmodule

// File: tb/tb_slow_debug_multi.sv
// Random + directed bench for slow_debug_multi against a remaining-cycles reference model.
module tb_slow_debug_multi;

  localparam int NCH  = 8;
  localparam int CW   = 8;
  localparam int MW   = 8;
  localparam int MAXM = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    I_fast;
  logic [CW-1:0]     I_hold;
  logic [NCH-1:0]    I_toggle_mode;
  logic              I_retrigger;
  logic              I_clear_merged;
  logic [NCH-1:0]    O_slow;
  logic [NCH*MW-1:0] O_merged;
  logic              O_active;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  slow_debug_multi #(.pCHANNELS(NCH), .pCOUNT_WIDTH(CW), .pMERGE_WIDTH(MW)) dut (
    .clk(clk), .reset(reset), .I_fast(I_fast), .I_hold(I_hold),
    .I_toggle_mode(I_toggle_mode), .I_retrigger(I_retrigger),
    .I_clear_merged(I_clear_merged), .O_slow(O_slow), .O_merged(O_merged),
    .O_active(O_active)
  );

  // Reference model: each channel is either free, counting down remaining
  // hold cycles, or (remaining == 0 while busy) waiting for the input to drop.
  bit m_slow   [NCH];
  bit m_busy   [NCH];
  int m_rem    [NCH];
  int m_merged [NCH];
  bit m_pf     [NCH];
  bit m_pm     [NCH];
  bit m_active;

  always @(posedge clk or posedge reset) begin : model
    int hl;
    bit any_busy;
    bit e;
    if (reset) begin
      for (int n = 0; n < NCH; n++) begin
        m_slow[n] = 0; m_busy[n] = 0; m_rem[n] = 0;
        m_merged[n] = 0; m_pf[n] = 0; m_pm[n] = 0;
      end
      m_active = 0;
    end else begin
      hl = (int'(I_hold) == 0) ? 1 : int'(I_hold);
      any_busy = 0;
      for (int n = 0; n < NCH; n++) any_busy = any_busy | m_busy[n];
      for (int n = 0; n < NCH; n++) begin
        e = I_fast[n] && !m_pf[n];
        if (I_toggle_mode[n] != m_pm[n]) begin
          m_busy[n] = 0; m_slow[n] = 0; m_rem[n] = 0;
        end else if (I_toggle_mode[n]) begin
          if (e) m_slow[n] = !m_slow[n];
        end else if (!m_busy[n]) begin
          if (e) begin m_busy[n] = 1; m_slow[n] = 1; m_rem[n] = hl; end
        end else if (m_rem[n] > 0) begin
          if (e && m_merged[n] < MAXM) m_merged[n] = m_merged[n] + 1;
          if (e && I_retrigger) m_rem[n] = hl;
          else begin
            m_rem[n] = m_rem[n] - 1;
            if (m_rem[n] == 0 && !I_fast[n]) begin m_busy[n] = 0; m_slow[n] = 0; end
          end
        end else if (!I_fast[n]) begin
          m_busy[n] = 0; m_slow[n] = 0;
        end
        if (I_clear_merged) m_merged[n] = 0;
        m_pf[n] = I_fast[n];
        m_pm[n] = I_toggle_mode[n];
      end
      m_active = any_busy;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [NCH-1:0]    es;
    logic [NCH*MW-1:0] em;
    @(negedge clk);
    if (chk_en) begin
      for (int n = 0; n < NCH; n++) begin
        es[n] = m_slow[n];
        em[n*MW +: MW] = MW'(m_merged[n]);
      end
      check("model_slow", longint'(O_slow), longint'(es));
      check("model_active", longint'(O_active), longint'(m_active));
      check("model_merged", longint'(O_merged), longint'(em));
    end
  endtask

  task automatic measure(input int ch, input int ncyc, input logic [63:0] wave,
                         output int hi, output int first);
    hi = 0;
    first = -1;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (O_slow[ch]) begin
        hi++;
        if (first < 0) first = i;
      end
      I_fast[ch] = (i < 64) ? wave[i] : 1'b0;
    end
    I_fast[ch] = 1'b0;
  endtask

  task automatic clear_merged();
    I_clear_merged = 1'b1;
    tick();
    I_clear_merged = 1'b0;
  endtask

  initial begin
    int hi, first, trans;
    bit prev;
    reset = 1'b1;
    I_fast = '0; I_hold = '0; I_toggle_mode = '0;
    I_retrigger = 1'b0; I_clear_merged = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    check("reset_slow", longint'(O_slow), 0);
    check("reset_active", longint'(O_active), 0);
    check("reset_merged", longint'(O_merged), 0);
    reset = 1'b0;
    tick();

    // Single-cycle pulse, hold 10.
    I_hold = 8'd10;
    measure(0, 20, 64'h1, hi, first);
    check("p10_len", hi, 10);
    check("p10_start", first, 1);
    check("p10_merged", longint'(O_merged[7:0]), 0);

    // Hold 0 behaves as 1.
    I_hold = 8'd0;
    measure(0, 6, 64'h1, hi, first);
    check("p0_len", hi, 1);

    // Wide input outlasts the hold.
    I_hold = 8'd4;
    measure(0, 30, 64'hFFFFF, hi, first);
    check("wide_len", hi, 20);

    // Merged edges without and with retrigger.
    I_hold = 8'd8;
    clear_merged();
    measure(0, 25, 64'h49, hi, first);
    check("noretrig_len", hi, 8);
    check("noretrig_merged", longint'(O_merged[7:0]), 2);
    clear_merged();
    I_retrigger = 1'b1;
    measure(0, 25, 64'h49, hi, first);
    check("retrig_len", hi, 14);
    check("retrig_merged", longint'(O_merged[7:0]), 2);

    // Saturation of merged counter on ch1.
    I_hold = 8'd255;
    for (int k = 0; k < 301; k++) begin
      I_fast[1] = 1'b1; tick();
      I_fast[1] = 1'b0; tick();
    end
    check("sat_merged", longint'(O_merged[15:8]), MAXM);
    repeat (260) tick();
    check("sat_done", longint'(O_slow[1]), 0);
    clear_merged();
    check("sat_cleared", longint'(O_merged[15:8]), 0);
    I_retrigger = 1'b0;

    // Toggle mode on ch3.
    I_toggle_mode[3] = 1'b1;
    tick(); tick();
    prev = O_slow[3];
    trans = 0;
    for (int k = 0; k < 5; k++) begin
      I_fast[3] = 1'b1; tick();
      if (O_slow[3] != prev) trans++;
      prev = O_slow[3];
      I_fast[3] = 1'b0; tick();
      if (O_slow[3] != prev) trans++;
      prev = O_slow[3];
    end
    tick();
    if (O_slow[3] != prev) trans++;
    check("tog_count", trans, 5);
    check("tog_final", longint'(O_slow[3]), 1);
    check("tog_active", longint'(O_active), 0);
    I_toggle_mode[3] = 1'b0;
    tick();
    check("tog_exit_slow", longint'(O_slow[3]), 0);
    check("tog_exit_active", longint'(O_active), 0);

    // Reset mid-hold.
    I_hold = 8'd50;
    clear_merged();
    measure(0, 10, 64'h9, hi, first);
    check("pre_rst_active", longint'(O_active), 1);
    check("pre_rst_merged", longint'(O_merged[7:0]), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_slow", longint'(O_slow), 0);
    check("rst_active", longint'(O_active), 0);
    check("rst_merged", longint'(O_merged), 0);
    tick(); tick();
    reset = 1'b0;
    measure(0, 60, 64'h1, hi, first);
    check("post_rst_len", hi, 50);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int n = 0; n < NCH; n++)
        if ($urandom_range(3) == 0) I_fast[n] = ~I_fast[n];
      if ($urandom_range(49) == 0) I_hold = CW'($urandom_range(12));
      if ($urandom_range(99) == 0) I_retrigger = ~I_retrigger;
      if ($urandom_range(199) == 0) I_toggle_mode[$urandom_range(NCH-1)] ^= 1'b1;
      I_clear_merged = ($urandom_range(63) == 0);
    end
    I_fast = '0;
    I_clear_merged = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slow_debug_multi.md
# slow_debug_multi

Multi-channel, parametrised pulse stretcher that makes short internal strobes visible on slow logic analysers and debug headers. Each channel stretches rising-edge pulses to a runtime-programmable length or, in toggle mode, converts each edge into an output transition. Per-channel counters record edges merged into an already-stretched pulse. Sits between internal trigger/glitch/capture strobes and the debug output mux.

## Interface
Parameters:
- pCHANNELS, 8, number of independent channels.
- pCOUNT_WIDTH, 8, width of the hold-length input and per-channel down-counter.
- pMERGE_WIDTH, 8, width of each per-channel merged-edge counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- I_fast  input  pCHANNELS  fast strobes, one per channel.
- I_hold  input  pCOUNT_WIDTH  stretch length in cycles, shared by all channels; 0 treated as 1.
- I_toggle_mode  input  pCHANNELS  per channel: 1 = toggle mode, 0 = stretch mode.
- I_retrigger  input  1  1 = an edge during HOLD reloads the counter.
- I_clear_merged  input  1  synchronous clear of all merged counters.
- O_slow  output  pCHANNELS  stretched/toggled outputs, registered.
- O_merged  output  pCHANNELS*pMERGE_WIDTH  merged-edge counters; channel n in bits [n*pMERGE_WIDTH +: pMERGE_WIDTH].
- O_active  output  1  registered OR of all channels not in IDLE (stretch mode only).

## Operation
- Edge detect per channel: edge = I_fast & ~fast_r, where fast_r is I_fast registered.
- Reset values: O_slow = 0, O_merged = 0, O_active = 0, fast_r = 0, counters = 0, all channels in IDLE.
- Stretch mode FSM per channel: IDLE, HOLD, WAIT_LOW.
  - IDLE: on edge, load count = max(I_hold,1), O_slow <= 1, go to HOLD. Not counted as merged.
  - HOLD: count decrements each cycle. On edge: merged counter increments (saturates at all-ones); if I_retrigger, count reloads to max(I_hold,1) instead of decrementing.
  - HOLD with count == 1 and no reloading edge: if I_fast = 0, go to IDLE with O_slow <= 0; else go to WAIT_LOW.
  - WAIT_LOW: O_slow stays 1; when I_fast sampled 0, go to IDLE with O_slow <= 0.
- I_hold is sampled only at load/reload; changes mid-HOLD do not affect the running count.
- Toggle mode: each edge inverts O_slow; FSM held in IDLE; merged counter not updated.
- Changing a channel's I_toggle_mode bit, detected by comparing against a registered copy, forces that channel to IDLE with O_slow <= 0 on the next cycle. An edge on that cycle is dropped.
- I_clear_merged zeroes all merged counters. A simultaneous merge increment is lost, because clear wins.
- Reset asserted mid-pulse drops O_slow immediately, without waiting for a clock.

## Timing
- Latency: O_slow rises on the clock edge after the edge is sampled. This is 1 cycle, or 3 cycles with the synchroniser compiled in.
- Stretch length: for an isolated input pulse of width W cycles, O_slow is high for exactly max(max(I_hold,1), W) cycles.
- Retrigger: O_slow stays high for max(I_hold,1) cycles after the last reloading edge.
- O_merged updates the cycle after the merged edge.
- O_active tracks the FSM states with 1 cycle of register latency.

## Configuration
- SLOW_DEBUG_SYNC_EN defined: each I_fast bit passes through a 2-flop synchroniser (reset to 0) before edge detection. Inputs may be asynchronous to clk, and all latencies increase by 2 cycles.
- SLOW_DEBUG_SYNC_EN not defined: I_fast must be synchronous to clk; no added latency.

## Test plan
- Single-cycle pulse on ch0, I_hold=10, stretch mode -> O_slow[0] high exactly 10 cycles, starting 1 cycle after the pulse; O_merged ch0 = 0.
- I_hold=0, 1-cycle pulse -> O_slow high exactly 1 cycle. I_hold=4 with a 20-cycle-wide input -> O_slow high 20 cycles and deasserts 1 cycle after input falls (WAIT_LOW path).
- I_hold=8, pulses at t=0, 3, 6 -> with I_retrigger=0, O_slow high 8 cycles and merged=2; with I_retrigger=1, high 14 cycles and merged=2.
- 300 merged edges with pMERGE_WIDTH=8 -> counter saturates at 255. Pulse I_clear_merged -> 0.
- Toggle mode on ch3, 5 edges -> O_slow[3] toggles 5 times and ends at 1. Clear the mode bit -> O_slow[3] = 0 next cycle, O_active unaffected.
- Assert reset mid-HOLD with I_hold=50 -> O_slow, O_active, and O_merged are 0 immediately. After release, a new edge produces a full 50-cycle pulse.
